// File: rtl/i2c_start_scheduler_pkg.sv
// rtl/i2c_start_scheduler_pkg.sv - shared state encodings and helpers for the start scheduler
package i2c_start_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_t;

    // Where the scheduler goes when a countdown completes; periodic is only looked at here.
    function automatic sched_state_t tick_next(input logic periodic);
        return periodic ? ST_RUN : ST_DONE;
    endfunction

endpackage

// File: rtl/i2c_tick_counter.sv
// rtl/i2c_tick_counter.sv - up-counter with enable, clear and a registered terminal-count tick
module i2c_tick_counter #(
    parameter int CNT_W = 28
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             count_en,
    input  logic             clear,
    input  logic [CNT_W-1:0] target,
    output logic             wrap,
    output logic             tick
);

    logic [CNT_W-1:0] count;

    // wrap is the same-edge terminal condition; tick is its registered copy one cycle later.
    assign wrap = count_en && !clear && (count == target - CNT_W'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= wrap;
            if (clear || wrap) begin
                count <= '0;
            end else if (count_en) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_start_scheduler.sv
// rtl/i2c_start_scheduler.sv - power-up and periodic start request generator for the I2C master
module i2c_start_scheduler
    import i2c_start_scheduler_pkg::*;
#(
    parameter int CNT_W         = 28,
    parameter int INIT_CYCLES   = 100000000,
    parameter int PERIOD_CYCLES = 100000000,
    parameter int OVR_W         = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             periodic,
    input  logic             rearm,
    input  logic             master_busy,
    output logic             start,
    output logic             pending,
    output logic [OVR_W-1:0] overrun_count,
    output logic             done
);

    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    if (INIT_CYCLES < 1 || PERIOD_CYCLES < 2 ||
        longint'(INIT_CYCLES) > CNT_MAX || longint'(PERIOD_CYCLES) > CNT_MAX) begin : g_param_check
        $error("i2c_start_scheduler: INIT_CYCLES/PERIOD_CYCLES out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] INIT_T   = CNT_W'(INIT_CYCLES);
    localparam logic [CNT_W-1:0] PERIOD_T = CNT_W'(PERIOD_CYCLES);

    sched_state_t     state;
    logic             pend_q;
    logic             wrap;
    logic             tick;
    logic             rearm_go;
    logic             count_en;
    logic             clear;
    logic             issue_ok;
    logic [CNT_W-1:0] target;

    assign rearm_go = enable && rearm && (state == ST_DONE);
    // The rearm edge already counts as the first cycle of the new period.
    assign count_en = enable && ((state != ST_DONE) || rearm);
    assign clear    = (state == ST_DONE) && !rearm_go;
    assign target   = (state == ST_INIT) ? INIT_T : PERIOD_T;
    assign issue_ok = enable && !master_busy;

    i2c_tick_counter #(
        .CNT_W(CNT_W)
    ) u_tick_counter (
        .clock    (clock),
        .reset    (reset),
        .count_en (count_en),
        .clear    (clear),
        .target   (target),
        .wrap     (wrap),
        .tick     (tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_INIT;
            start         <= 1'b0;
            pend_q        <= 1'b0;
            overrun_count <= '0;
        end else begin
            start <= 1'b0;
            if (wrap) begin
                state <= tick_next(periodic);
            end else if (rearm_go) begin
                state <= ST_RUN;
            end

            // A tick arriving while a request is already held is lost and counted.
            if (pend_q) begin
                if (issue_ok) begin
                    start  <= 1'b1;
                    pend_q <= 1'b0;
                end
                if (tick && (overrun_count != '1)) begin
                    overrun_count <= overrun_count + OVR_W'(1);
                end
            end else if (tick) begin
                if (issue_ok) begin
                    start <= 1'b1;
                end else begin
                    pend_q <= 1'b1;
                end
            end
        end
    end

    assign pending = pend_q || tick;
    assign done    = (state == ST_DONE);

endmodule
